ifu_fetch: RTL

//  Instruction-fetch initiator for the RV32 core: owns the PC, drives the cs/addr read port of the

---
 rtl/ifu_fetch_pkg.sv | 26 ++
 rtl/ifu_fetch_fifo.sv | 64 ++++++
 rtl/ifu_fetch.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_pkg.sv
// ============================================================================
// Module  : ifu_fetch_pkg
// Brief   : Shared constants and FSM state encodings for the fetch unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ifu_fetch_pkg;

  localparam int unsigned c_aw_default = 32;
  localparam int unsigned c_dw_default = 32;

  // Simulation boot address.
  localparam logic [31:0] c_address_sim = 32'h0000_0000;

  localparam int unsigned c_fifo_depth = 2;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/ifu_fetch_fifo.sv
// ============================================================================
// Module  : ifu_fetch_fifo
// Brief   : Two-entry {pc,instr} FIFO with flush, push, pop and occupancy.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_fetch_fifo #(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic [1:0]   cnt
);

  logic [W-1:0] r_mem [0:1];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_cnt;
  logic         w_push;
  logic         w_pop;

  assign w_pop  = pop & (r_cnt != 2'd0);
  assign w_push = push & ((r_cnt != 2'd2) | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else if (flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= wdata;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Head reads as zero while empty so downstream never sees stale entries.
  assign rdata = (r_cnt != 2'd0) ? r_mem[r_rd_ptr] : '0;
  assign cnt   = r_cnt;

endmodule

`default_nettype wire

// File: rtl/ifu_fetch.sv
// ============================================================================
// Module  : ifu_fetch
// Brief   : RV32 instruction-fetch initiator: PC, imem read port, 2-deep
//           decode queue. Optional IFU_MISALIGN_CHK_EN traps misaligned
//           redirects into an error state.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int unsigned    AW       = c_aw_default,
  parameter int unsigned    DW       = c_dw_default,
  parameter logic [AW-1:0]  RESET_PC = AW'(c_address_sim)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_cs,
  output logic [AW-1:0] imem_addr,
  input  logic [DW-1:0] imem_rdata,
  output logic          if_valid,
  input  logic          if_ready,
  output logic [AW-1:0] if_pc,
  output logic [DW-1:0] if_instr,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          fetch_err
);

  fetch_state_e     r_state;
  fetch_state_e     w_state_nxt;
  logic [AW-1:0]    r_pc;
  logic [AW-1:0]    r_req_pc;
  logic             r_pend;
  logic             r_kill;
  logic             w_issue;
  logic             w_pop;
  logic             w_push;
  logic             w_misaligned;
  logic [AW-1:0]    w_redirect_tgt;
  logic [1:0]       w_cnt;
  logic [2:0]       w_occ;
  logic [AW+DW-1:0] w_head;

`ifdef IFU_MISALIGN_CHK_EN
  logic r_fetch_err;

  assign w_misaligned   = redirect_valid & (redirect_pc[1:0] != 2'b00);
  assign w_redirect_tgt = redirect_pc;
  assign fetch_err      = r_fetch_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_err <= 1'b0;
    end else if (redirect_valid) begin
      r_fetch_err <= w_misaligned;
    end
  end
`else
  localparam logic [AW-1:0] c_align_mask = ~AW'(3);

  assign w_misaligned   = 1'b0;
  assign w_redirect_tgt = redirect_pc & c_align_mask;
  assign fetch_err      = 1'b0;
`endif

  assign if_valid = (w_cnt != 2'd0);
  assign w_pop    = if_valid & if_ready;
  // Slots committed after this cycle: queued + in flight - leaving.
  assign w_occ    = {1'b0, w_cnt} + {2'b00, r_pend} - {2'b00, w_pop};
  assign w_push   = r_pend & ~r_kill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      ST_BOOT: begin
        w_state_nxt = w_misaligned ? ST_ERR : ST_RUN;
      end
      ST_RUN: begin
        if (w_misaligned) begin
          w_state_nxt = ST_ERR;
        end else begin
          w_issue = !redirect_valid && (w_occ < 3'd2);
        end
      end
`ifdef IFU_MISALIGN_CHK_EN
      ST_ERR: begin
        if (redirect_valid && !w_misaligned) begin
          w_state_nxt = ST_RUN;
        end
      end
`endif
      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  assign imem_cs   = w_issue;
  assign imem_addr = {2'b00, r_pc[AW-1:2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_req_pc <= '0;
      r_pend   <= 1'b0;
      r_kill   <= 1'b0;
    end else begin
      r_pend <= w_issue;
      // A response still owed at redirect time belongs to the old path.
      r_kill <= redirect_valid & r_pend;
      if (redirect_valid) begin
        r_pc <= w_redirect_tgt;
      end else if (w_issue) begin
        r_pc     <= r_pc + AW'(4);
        r_req_pc <= r_pc;
      end
    end
  end

  ifu_fetch_fifo #(
    .W (AW + DW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (w_push),
    .wdata ({r_req_pc, imem_rdata}),
    .pop   (w_pop),
    .rdata (w_head),
    .cnt   (w_cnt)
  );

  assign if_pc    = w_head[AW+DW-1:DW];
  assign if_instr = w_head[DW-1:0];

endmodule

`default_nettype wire
